// File: rtl/taxi_distance_meter.sv
// rtl/taxi_distance_meter.sv - distance-tick prescaler and BCD fare down-counter
// Runs the remaining-distance BCD counter per fare mode and counts fare pulses.
module taxi_distance_meter #(
  parameter int                  DIGITS         = 3,
  parameter int                  TICK_DIV       = 10,
  parameter logic [4*DIGITS-1:0] RELOAD_NORMAL  = 12'h140,
  parameter logic [4*DIGITS-1:0] RELOAD_PREMIUM = 12'h120,
  parameter int                  CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_normal,
  input  logic                  start_premium,
  input  logic                  stop,
  input  logic                  pause,
  output logic [1:0]            mode,
  output logic                  running,
  output logic [4*DIGITS-1:0]   remain_bcd,
  output logic                  fare_pulse,
  output logic [CNT_W-1:0]      pulse_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [4*DIGITS-1:0] BCD_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_NORMAL  = 2'b01,
    S_PREMIUM = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [PW-1:0]         r_presc;
  logic [4*DIGITS-1:0]   r_remain;
  logic                  r_fare_pulse;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_running;
  logic                  w_tick;
  logic                  w_start;
  logic [4*DIGITS-1:0]   w_reload_next;

  function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] res;
    logic                borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_running    = (r_state != S_IDLE);
    if (stop)               w_state_next = S_IDLE;
    else if (start_normal)  w_state_next = S_NORMAL;
    else if (start_premium) w_state_next = S_PREMIUM;
    w_start       = !w_running && (w_state_next != S_IDLE);
    w_tick        = w_running && !pause && (r_presc == PRESC_MAX);
    // A mode switch coincident with a tick reloads with the new mode's value.
    w_reload_next = (w_state_next == S_PREMIUM) ? RELOAD_PREMIUM : RELOAD_NORMAL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_remain     <= '0;
      r_fare_pulse <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_fare_pulse <= 1'b0;
      if (w_start) begin
        r_remain <= w_reload_next;
        r_presc  <= '0;
        r_cnt    <= '0;
      end else if (w_running) begin
        if (stop) begin
          r_presc <= '0;
        end else begin
          if (!pause) r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            if (r_remain == BCD_ONE) begin
              r_remain     <= w_reload_next;
              r_fare_pulse <= 1'b1;
              if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_remain <= bcd_dec(r_remain);
            end
          end
        end
      end
    end
  end

  assign mode        = r_state;
  assign running     = (r_state != S_IDLE);
  assign remain_bcd  = r_remain;
  assign fare_pulse  = r_fare_pulse;
  assign pulse_count = r_cnt;

endmodule

// File: doc/taxi_distance_meter.md
# taxi_distance_meter

Parametrised distance-fare engine for the taximeter. It divides `clk` into distance ticks and runs an N-digit BCD down-counter that reloads per fare mode. It emits a one-cycle `fare_pulse` each time a distance unit is used up, and keeps a saturating count of those pulses. It feeds the fare accumulator and the 7-segment remaining-distance display.

## Interface
- `DIGITS`, default 3: number of BCD digits in the remaining-distance counter (≥1).
- `TICK_DIV`, default 10: `clk` cycles per distance tick (≥1).
- `RELOAD_NORMAL`, default `12'h140`: BCD reload for normal mode, `4*DIGITS` bits. Must be nonzero, valid BCD.
- `RELOAD_PREMIUM`, default `12'h120`: BCD reload for premium mode. Same rules as `RELOAD_NORMAL`.
- `CNT_W`, default 16: width of `pulse_count`.

Ports:
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: synchronous, active-high; clock `clk`.
- `start_normal` input, 1 bit: level; start in, or switch to, normal mode.
- `start_premium` input, 1 bit: level; start in, or switch to, premium mode.
- `stop` input, 1 bit: level; end trip and return to idle.
- `pause` input, 1 bit: level; freeze prescaler (vehicle stopped).
- `mode` output, 2 bits: `00` idle, `01` normal, `10` premium; `11` never driven.
- `running` output, 1 bit: `mode != 00`.
- `remain_bcd` output, `4*DIGITS` bits: remaining distance ticks in BCD, digit 0 in LSBs.
- `fare_pulse` output, 1 bit: one-cycle strobe per exhausted distance unit.
- `pulse_count` output, `CNT_W` bits: fare pulses this trip, saturating.

## Operation
- States: IDLE, NORMAL, PREMIUM. Command priority on each edge: `reset` > `stop` > `start_normal` > `start_premium`.
- Reset: mode=IDLE, prescaler=0, `remain_bcd`=0, `fare_pulse`=0, `pulse_count`=0.
- IDLE + start_x:
  - go to mode x;
  - `remain_bcd` ← RELOAD_x;
  - prescaler ← 0;
  - `pulse_count` ← 0.
- NORMAL/PREMIUM + start of the other mode:
  - switch mode;
  - `remain_bcd`, prescaler and `pulse_count` unchanged;
  - subsequent reloads use the new mode's value.
- Start of the current mode while running: no effect.
- `stop` while running:
  - go to IDLE;
  - prescaler ← 0;
  - `remain_bcd` and `pulse_count` hold (display frozen until next start);
  - no `fare_pulse` generated on that edge.
- Prescaler:
  - counts 0..TICK_DIV-1 only while running and `pause`=0, then wraps;
  - tick = running & !pause & (prescaler == TICK_DIV-1);
  - `pause` holds the prescaler value; it is not cleared.
- On a tick:
  - if `remain_bcd` == 1: `remain_bcd` ← RELOAD of the current mode and `fare_pulse`=1 for the next cycle;
  - else: BCD decrement (digit 0 → 9 with borrow into the next digit).
- `pulse_count` increments with each `fare_pulse` and saturates at all-ones.
- `remain_bcd` is never 0 while running.
- Simultaneous tick and mode switch: the decrement or reload of that edge uses the NEW mode's reload value.
- Simultaneous tick and `stop`: `stop` wins, with no decrement and no pulse.

## Timing
- Start sampled at edge E0: after E0, `running`=1, `remain_bcd`=RELOAD, prescaler=0.
- The first tick is applied at edge E(TICK_DIV). Subsequent ticks follow every TICK_DIV edges, extended by paused cycles.
- With no pause, the k-th `fare_pulse` is high in the cycle following edge E(k·R·TICK_DIV), where R is the reload as a decimal value.
- The `pulse_count` update is coincident with `fare_pulse` high.
- TICK_DIV=1: tick on every running, unpaused edge.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
1. Reset check: assert `reset` mid-trip → next cycle `mode`=0, `remain_bcd`=0, `pulse_count`=0, `fare_pulse`=0.
2. Normal run, DIGITS=3, TICK_DIV=4, RELOAD_NORMAL=`12'h012`, `start_normal` one cycle:
   - `remain_bcd` goes 012, 011 (after 4 cycles), …, 010, 009 (borrow);
   - first `fare_pulse` 48 cycles after start, then `remain_bcd`=012 and `pulse_count`=1.
3. Mode switch: with RELOAD_PREMIUM=`12'h005`, switch to premium at `remain_bcd`=003 → continues 002, 001, pulse, reload 005.
4. Pause: assert `pause` for 10 cycles mid-interval → the next tick and pulse are delayed by exactly 10 cycles; `remain_bcd` is unchanged during the pause.
5. Stop and restart:
   - `stop` on a tick edge with `remain_bcd`=001 → no pulse; IDLE; `remain_bcd` holds 001;
   - a later `start_premium` reloads 005 and clears `pulse_count`.
6. Saturation: CNT_W=2, RELOAD=`12'h001`, TICK_DIV=1 → a pulse every cycle; `pulse_count` stops at 3.
